// File: rtl/fft_pkg.sv
// Shared types and helpers for the 64-point FFT output reorder buffer:
// default sizes, bin-index bit reversal and the read-side FSM state type.
package fft_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int FFT_POINTS_DEF = 64;
  localparam int LOG2N_DEF      = $clog2(FFT_POINTS_DEF);

  // Widest index the bit-reversal helper supports; callers truncate to LOG2N.
  localparam int BITREV_MAX_W = 16;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int                      log2n
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < log2n) r[log2n-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame memory for the reorder buffer: one write port and one
// registered read port. The read register doubles as the block's data output.
module fft_reorder_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data is cleared by reset because it drives the block outputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft64_reorder.sv
// Bit-reversed to natural-order reorder buffer behind the SDF FFT (ping-pong banks).
// Optional FFT_REORDER_SYNC_EN: in_sof restarts the frame being collected.
module fft64_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FFT_POINTS = FFT_POINTS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_en,
  input  logic [WIDTH-1:0]              in_real,
  input  logic [WIDTH-1:0]              in_img,
  input  logic                          in_sof,
  output logic                          out_en,
  output logic [WIDTH-1:0]              out_real,
  output logic [WIDTH-1:0]              out_img,
  output logic [$clog2(FFT_POINTS)-1:0] out_index,
  output logic                          out_last
);

  localparam int LOG2N = $clog2(FFT_POINTS);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_POINTS - 1);

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] wr_rev;
  logic             wsel;
  logic             sof_restart;
  logic             launch;
  logic [LOG2N-1:0] rcnt;
  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             rd_vld_p0;
  logic [2*WIDTH-1:0] rd_data_p1;

`ifdef FFT_REORDER_SYNC_EN
  assign sof_restart = in_en & in_sof;
`else
  logic sof_unused;
  assign sof_unused  = in_sof;
  assign sof_restart = 1'b0;
`endif

  // Write side: a start-of-frame sample abandons the partial frame in place.
  assign wr_idx = sof_restart ? '0 : wcnt;
  assign wr_rev = LOG2N'(bitrev(BITREV_MAX_W'(wr_idx), LOG2N));
  assign launch = in_en & ~sof_restart & (wcnt == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      wsel <= 1'b0;
    end else begin
      if (in_en)  wcnt <= wr_idx + LOG2N'(1);
      if (launch) wsel <= ~wsel;
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:  if (launch) state_nxt = RD_BURST;
      RD_BURST: if ((rcnt == LAST_IDX) && !launch) state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_vld_p0 = (state == RD_BURST);
  end

  // rcnt wraps to 0 at the end of a burst, which also covers a chained launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rcnt <= '0;
    else if (rd_vld_p0) rcnt <= rcnt + LOG2N'(1);
    else                rcnt <= '0;
  end

  fft_reorder_ram #(
    .DATA_W (2*WIDTH),
    .ADDR_W (LOG2N+1)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_en),
    .wr_addr ({wsel, wr_rev}),
    .wr_data ({in_real, in_img}),
    .rd_en   (rd_vld_p0),
    .rd_addr ({~wsel, rcnt}),
    .rd_data (rd_data_p1)
  );

  // Stage p1: control aligned with the registered RAM read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_en    <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      out_en    <= rd_vld_p0;
      out_index <= rcnt;
      out_last  <= rd_vld_p0 & (rcnt == LAST_IDX);
    end
  end

  assign out_real = rd_data_p1[2*WIDTH-1:WIDTH];
  assign out_img  = rd_data_p1[WIDTH-1:0];

endmodule

// File: doc/fft64_reorder.md
# fft64_reorder

Output reorder buffer placed directly downstream of the three-stage radix-2² SDF 64-point FFT. The FFT emits each frame in bit-reversed index order. This block collects each 64-sample frame and replays it in natural frequency order (bin 0..63), tagged with bin index and end-of-frame. It uses a ping-pong RAM so continuous back-to-back frames flow without stalls or loss.

## Interface
- WIDTH, 16, bit width of each real/imag component
- FFT_POINTS, 64, frame length; power of two; LOG2N = log2(FFT_POINTS) is derived, not overridable
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_en  input  1  in_real/in_img valid this cycle; no backpressure
- in_real  input  WIDTH  FFT output real part, bit-reversed order
- in_img  input  WIDTH  FFT output imaginary part
- in_sof  input  1  first sample of a frame; used only under FFT_REORDER_SYNC_EN, otherwise ignored
- out_en  output  1  out_* valid this cycle
- out_real  output  WIDTH  real part, natural order
- out_img  output  WIDTH  imaginary part
- out_index  output  LOG2N  bin number of current output
- out_last  output  1  high with bin FFT_POINTS-1

## Operation
- Two banks of FFT_POINTS words, each 2*WIDTH bits wide. Write bank select wsel resets to 0.
- Write side:
  - 6-bit wcnt, reset 0. On in_en, write {in_real,in_img} to bank wsel at address bitrev(wcnt), then increment wcnt.
  - On the sample with wcnt = FFT_POINTS-1: wcnt wraps to 0, wsel toggles, and a read burst of the just-filled bank is launched.
- Read side FSM, two states:
  - IDLE to BURST on launch.
  - BURST: rcnt counts 0..FFT_POINTS-1 and reads bank !wsel at address rcnt; back to IDLE after rcnt = FFT_POINTS-1.
- A launch on the same cycle the burst ends is legal and chains directly: BURST stays, rcnt goes to 0.
- No overrun is possible. A burst lasts exactly FFT_POINTS cycles and a fill needs at least FFT_POINTS cycles, so the bank being read is never rewritten during its burst.
- Data is passed through unchanged; no scaling or rounding.
- Reset (any time, including mid-frame or mid-burst):
  - wcnt, rcnt, wsel go to 0; FSM goes to IDLE.
  - out_en, out_last, out_index, out_real, out_img go to 0.
  - RAM contents are not cleared; a partial frame is discarded.

## Timing
- The edge capturing the 64th sample is edge t. out_en rises at edge t+1 with bin 0; bins 1..63 follow on edges t+2..t+64. No gaps, regardless of in_en gaps.
- Continuous input (in_en held high): out_en stays high continuously starting one cycle after the first frame completes.
- RAM read is registered. out_* are registered outputs, with no combinational path from inputs.
- out_index equals the value of rcnt that issued the read; out_last = out_en & (out_index == FFT_POINTS-1).

## Configuration
- FFT_REORDER_SYNC_EN defined:
  - in_en & in_sof forces that sample to wcnt = 0 in the current bank, then wcnt = 1.
  - Any partial frame is dropped with no launch and no wsel toggle.
  - An in-progress burst is unaffected.
  - in_sof on a sample where wcnt is already 0 has no extra effect.
- Undefined: in_sof is ignored; frames are delimited purely by counting in_en.

## Structure
- Shared package fft_pkg:
  - WIDTH and FFT_POINTS defaults;
  - the LOG2N derivation;
  - the bitrev function (parameterised on LOG2N);
  - the read FSM state enum.
- One sub-module, fft_reorder_ram:
  - simple dual-port memory, depth 2*FFT_POINTS, width 2*WIDTH;
  - one write port and one registered read port;
  - address is {bank, index}.

## Test plan
- Single frame: in_real = n, in_img = -n for n = 0..63, in_en continuous. Expected:
  - out_real sequence 0,32,16,48,8,40,…,63, i.e. bitrev(k) at bin k;
  - out_index 0..63 and out_last only at 63;
  - first out_en exactly 1 cycle after the 64th input edge.
- Back-to-back frames: three frames with no in_en gap. Expected: out_en high for 192 consecutive cycles and every frame correctly reordered.
- Gapped input: in_en alternates 1/0. Expected:
  - output comes as 64-cycle solid bursts, one per 128 input cycles;
  - data correct.
- Reset after 30 samples of a frame, then a full clean frame. Expected:
  - all outputs 0 during and after reset;
  - only the clean frame is output, correct, with no remnants.
- With FFT_REORDER_SYNC_EN: 20 samples, then in_sof with a new frame of 64. Expected: a single output frame matching the new data; the 20 samples are never output.
- Burst/launch overlap: the 64th sample of frame 2 lands on the cycle bin 63 of frame 1 is output. Expected: bin 0 of frame 2 follows immediately.
